// File: rtl/lsu_dmem_ctrl.sv
// Load/store initiator between the core memory stage and a word-only data memory.
// Sub-word stores are read-modify-write; misaligned or illegal requests complete with rsp_err.
module lsu_dmem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_rw,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, RD_CAP, WR, RESP} state_t;

  state_t                  state_reg;
  logic [1:0]              addr_lo_reg;
  logic [2:0]              funct3_reg;
  logic                    we_reg;
  logic [15:0]             wdata_lo_reg;
  logic                    rsp_valid_reg;
  logic                    rsp_err_reg;
  logic [DATA_WIDTH-1:0]   rsp_rdata_reg;
  logic [ADDR_WIDTH-1:0]   mem_addr_reg;
  logic [DATA_WIDTH-1:0]   mem_wdata_reg;
  logic                    mem_rw_reg;

  logic                    req_err;
  logic [4:0]              byte_shift;
  logic [7:0]              byte_val;
  logic [15:0]             half_val;
  logic [DATA_WIDTH-1:0]   load_ext;
  logic [DATA_WIDTH-1:0]   merged;

  // Misalignment and illegal-code decode on the live request, used only at accept.
  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = req_addr[0];
      3'b010:  req_err = |req_addr[1:0];
      3'b100:  req_err = req_we;
      3'b101:  req_err = req_we | req_addr[0];
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    byte_shift = {addr_lo_reg, 3'b000};
    byte_val   = mem_rdata[byte_shift +: 8];
    half_val   = addr_lo_reg[1] ? mem_rdata[DATA_WIDTH-1:DATA_WIDTH/2] : mem_rdata[DATA_WIDTH/2-1:0];
    load_ext   = mem_rdata;
    case (funct3_reg)
      3'b000:  load_ext = {{(DATA_WIDTH-8){byte_val[7]}}, byte_val};
      3'b001:  load_ext = {{(DATA_WIDTH-16){half_val[15]}}, half_val};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, byte_val};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, half_val};
      default: load_ext = mem_rdata;
    endcase
    merged = mem_rdata;
    if (funct3_reg[0])
      merged[{addr_lo_reg[1], 4'b0000} +: 16] = wdata_lo_reg;
    else
      merged[byte_shift +: 8] = wdata_lo_reg[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      addr_lo_reg   <= '0;
      funct3_reg    <= '0;
      we_reg        <= 1'b0;
      wdata_lo_reg  <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_rw_reg    <= 1'b0;
    end else begin
      rsp_valid_reg <= 1'b0;
      mem_rw_reg    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            addr_lo_reg  <= req_addr[1:0];
            funct3_reg   <= req_funct3;
            we_reg       <= req_we;
            wdata_lo_reg <= req_wdata[15:0];
            if (req_err) begin
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
              state_reg     <= RESP;
            end else if (req_we && req_funct3 == 3'b010) begin
              mem_addr_reg  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_wdata_reg <= req_wdata;
              mem_rw_reg    <= 1'b1;
              state_reg     <= WR;
            end else begin
              mem_addr_reg  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              state_reg     <= RD;
            end
          end
        end
        RD: state_reg <= RD_CAP;
        RD_CAP: begin
          // Stores fall through to the write of the merged word; loads respond now.
          if (we_reg) begin
            mem_wdata_reg <= merged;
            mem_rw_reg    <= 1'b1;
            state_reg     <= WR;
          end else begin
            rsp_rdata_reg <= load_ext;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= 1'b0;
            state_reg     <= RESP;
          end
        end
        WR: begin
          rsp_valid_reg <= 1'b1;
          rsp_err_reg   <= 1'b0;
          state_reg     <= RESP;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_rw    = mem_rw_reg;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Directed bench for lsu_dmem_ctrl with a one-cycle-latency word memory model.
module tb_lsu_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rw;
  logic [31:0] mem_rdata = 32'h0;

  logic [31:0] mem [1024];

  int n_cmp = 0;
  int n_bad = 0;

  lsu_dmem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rw    (mem_rw),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory: samples address/write on the edge, read data valid the next cycle.
  always @(posedge clk) begin
    if (mem_rw) mem[mem_addr[11:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[11:2]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int exp_lat, input int exp_nwr, input logic [31:0] exp_wa,
                       input logic [31:0] exp_wd, input logic chk_rd,
                       input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    int nwr;
    logic [31:0] wa;
    logic [31:0] wd;
    lat = 0;
    nwr = 0;
    wa  = 32'h0;
    wd  = 32'h0;
    @(negedge clk);
    chk({tag, ".ready"}, {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (mem_rw) begin
        nwr++;
        wa = mem_addr;
        wd = mem_wdata;
      end
      if (rsp_valid) lat = k;
    end
    if (lat == 0) chk({tag, ".timeout"}, 32'h0, 32'h1);
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".err"}, {31'h0, rsp_err}, {31'h0, exp_err});
    chk({tag, ".nwr"}, 32'(nwr), 32'(exp_nwr));
    if (exp_nwr != 0) begin
      chk({tag, ".waddr"}, wa, exp_wa);
      chk({tag, ".wdata"}, wd, exp_wd);
    end
    if (chk_rd) chk({tag, ".rdata"}, rsp_rdata, exp_rd);
    $display("op %s: lat=%0d err=%0d nwr=%0d rdata=%h", tag, lat, rsp_err, nwr, rsp_rdata);
  endtask

  initial begin
    int nw;
    int nv;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.ready", {31'h0, req_ready}, 32'h1);
    chk("rst.rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst.mem_rw", {31'h0, mem_rw}, 32'h0);
    chk("rst.rdata", rsp_rdata, 32'h0);
    chk("rst.err", {31'h0, rsp_err}, 32'h0);
    chk("rst.maddr", mem_addr, 32'h0);
    $display("reset: ready=%0d rsp_valid=%0d mem_rw=%0d", req_ready, rsp_valid, mem_rw);

    //     tag        we    f3      addr          wdata          lat wr  waddr         wdata         rd    rdata         err
    do_op("sw100",   1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 2, 1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0,        1'b0);
    do_op("lw100",   1'b0, 3'b010, 32'h0000_0100, 32'h0,         3, 0, 32'h0,         32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0);
    do_op("sw100b",  1'b1, 3'b010, 32'h0000_0100, 32'h1122_3344, 2, 1, 32'h0000_0100, 32'h1122_3344, 1'b0, 32'h0,        1'b0);
    do_op("sb103",   1'b1, 3'b000, 32'h0000_0103, 32'h1234_565A, 4, 1, 32'h0000_0100, 32'h5A22_3344, 1'b0, 32'h0,        1'b0);
    do_op("lw100c",  1'b0, 3'b010, 32'h0000_0100, 32'h0,         3, 0, 32'h0,         32'h0,         1'b1, 32'h5A22_3344, 1'b0);
    do_op("sw200",   1'b1, 3'b010, 32'h0000_0200, 32'h80FF_7F01, 2, 1, 32'h0000_0200, 32'h80FF_7F01, 1'b0, 32'h0,        1'b0);
    do_op("lb201",   1'b0, 3'b000, 32'h0000_0201, 32'h0,         3, 0, 32'h0,         32'h0,         1'b1, 32'h0000_007F, 1'b0);
    do_op("lb203",   1'b0, 3'b000, 32'h0000_0203, 32'h0,         3, 0, 32'h0,         32'h0,         1'b1, 32'hFFFF_FF80, 1'b0);
    do_op("lbu203",  1'b0, 3'b100, 32'h0000_0203, 32'h0,         3, 0, 32'h0,         32'h0,         1'b1, 32'h0000_0080, 1'b0);
    do_op("lh202",   1'b0, 3'b001, 32'h0000_0202, 32'h0,         3, 0, 32'h0,         32'h0,         1'b1, 32'hFFFF_80FF, 1'b0);
    do_op("lh200",   1'b0, 3'b001, 32'h0000_0200, 32'h0,         3, 0, 32'h0,         32'h0,         1'b1, 32'h0000_7F01, 1'b0);
    do_op("lhu202",  1'b0, 3'b101, 32'h0000_0202, 32'h0,         3, 0, 32'h0,         32'h0,         1'b1, 32'h0000_80FF, 1'b0);
    do_op("lw102e",  1'b0, 3'b010, 32'h0000_0102, 32'h0,         1, 0, 32'h0,         32'h0,         1'b1, 32'h0000_80FF, 1'b1);
    do_op("sh101e",  1'b1, 3'b001, 32'h0000_0101, 32'h0000_ABCD, 1, 0, 32'h0,         32'h0,         1'b1, 32'h0000_80FF, 1'b1);
    do_op("f3_011e", 1'b0, 3'b011, 32'h0000_0100, 32'h0,         1, 0, 32'h0,         32'h0,         1'b1, 32'h0000_80FF, 1'b1);
    do_op("lw100d",  1'b0, 3'b010, 32'h0000_0100, 32'h0,         3, 0, 32'h0,         32'h0,         1'b1, 32'h5A22_3344, 1'b0);

    // Reset asserted while the SH read-modify-write sits in RD_CAP.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b001;
    req_addr   = 32'h0000_0102;
    req_wdata  = 32'h0000_BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    nw = 0;
    nv = 0;
    for (int k = 0; k < 6; k++) begin
      if (mem_rw) nw++;
      if (rsp_valid) nv++;
      @(negedge clk);
      rst_n = 1'b1;
    end
    chk("rstmid.nwr", 32'(nw), 32'h0);
    chk("rstmid.rsp_valid", 32'(nv), 32'h0);
    chk("rstmid.ready", {31'h0, req_ready}, 32'h1);
    $display("reset mid-RMW: writes=%0d responses=%0d ready=%0d", nw, nv, req_ready);

    do_op("lw100e",  1'b0, 3'b010, 32'h0000_0100, 32'h0,         3, 0, 32'h0,         32'h0,         1'b1, 32'h5A22_3344, 1'b0);
    do_op("sh102",   1'b1, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 4, 1, 32'h0000_0100, 32'hBEEF_3344, 1'b0, 32'h0,        1'b0);
    do_op("lhu102",  1'b0, 3'b101, 32'h0000_0102, 32'h0,         3, 0, 32'h0,         32'h0,         1'b1, 32'h0000_BEEF, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_ctrl.md
Name: lsu_dmem_ctrl

Overview:
- Load/store initiator between the core's memory stage and the word-only data memory.
- Core side: byte, halfword and word accesses.
- Memory side: always word-aligned reads and writes, to a memory that returns read data one clock after the address is sampled.
- Sub-word stores are done as read-modify-write. Misaligned or illegal requests complete with an error flag and make no memory access.

Parameters:
- DATA_WIDTH, 32, data bus width on both sides. Only 32 is supported.
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk, input, 1: rising-edge clock for all state.
- rst_n, input, 1: synchronous, active-low reset.
- req_valid, input, 1: core request strobe.
- req_ready, output, 1: high only in IDLE. A request is accepted on an edge where req_valid && req_ready.
- req_we, input, 1: 1 = store, 0 = load.
- req_funct3, input, 3: RISC-V funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- req_addr, input, ADDR_WIDTH: byte address.
- req_wdata, input, DATA_WIDTH: store data, right-aligned.
- rsp_valid, output, 1: one-cycle completion pulse.
- rsp_rdata, output, DATA_WIDTH: extended load result. Held until the next response.
- rsp_err, output, 1: misaligned access or illegal funct3. Valid with rsp_valid.
- mem_addr, output, ADDR_WIDTH: word address to memory. Bits [1:0] are always 00.
- mem_wdata, output, DATA_WIDTH: write data to memory.
- mem_rw, output, 1: 0 = read, 1 = write. Sampled by memory on clk.
- mem_rdata, input, DATA_WIDTH: memory read data. Valid in the cycle after a read cycle.

Behaviour:
- Reset (rst_n low at an edge):
  - State goes to IDLE.
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
  - mem_rw = 0, mem_addr = 0, mem_wdata = 0.
  - Any in-flight operation is aborted.
  - If reset is sampled before the WR cycle of a read-modify-write, no write is issued.
- On accept, the controller latches addr, funct3, we and wdata. All later cycles use the latched copies only.
- States: IDLE, RD, RD_CAP, WR, RESP. Memory outputs are decoded from registered state and latched request only.
- Error check at accept:
  - Misaligned: LH, LHU, SH with addr[0] = 1; LW, SW with addr[1:0] != 00.
  - Illegal funct3: any code not in the lists above.
  - Path: IDLE -> RESP with rsp_err = 1. No mem_rw = 1 cycle and no read is issued; rsp_rdata is unchanged.
- Load path: IDLE -> RD -> RD_CAP -> RESP -> IDLE.
  - RD: mem_addr = {addr[31:2], 2'b00}, mem_rw = 0.
  - RD_CAP: mem_rdata is captured and extracted.
  - Byte lane = addr[1:0]*8; half lane = addr[1]*16.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
  - rsp_valid is high in the 3rd cycle after the accept edge.
- Word store path: IDLE -> WR -> RESP.
  - WR: mem_rw = 1, mem_wdata = wdata.
  - rsp_valid is high in the 2nd cycle after accept.
- Sub-word store path (SB, SH): IDLE -> RD -> RD_CAP -> WR -> RESP.
  - RD_CAP merges the selected byte or half of wdata[7:0] / wdata[15:0] into the captured word. All other bytes are preserved.
  - WR writes the merged word.
  - rsp_valid is high in the 4th cycle after accept.
- Outside the RD and WR states: mem_rw = 0 and mem_addr holds its last value. The controller never drives mem_rw = 1 for more than one consecutive cycle.
- RESP lasts exactly one cycle, then returns to IDLE.
- req_ready is low in RESP, so back-to-back accepts are spaced by at least one IDLE cycle.
- req_valid while busy is ignored. The core holds its request until accepted.
- rsp_err is cleared to 0 on every non-error response.

Test Plan:
- Reset, then idle: rst_n low 2 cycles -> req_ready = 1, rsp_valid = 0, mem_rw = 0, rsp_rdata = 0.
- SW then LW at addr 0x100, wdata 0xDEADBEEF:
  - SW: exactly one mem_rw = 1 cycle at mem_addr 0x100, rsp_valid in cycle 2.
  - LW: rsp_rdata = 0xDEADBEEF in cycle 3, rsp_err = 0.
- SB 0x5A at addr 0x103 over memory word 0x11223344 -> read at 0x100, then write 0x5A223344, rsp_valid in cycle 4.
- Load extension from word 0x80FF7F01 at 0x200:
  - LB @0x201 -> 0x0000007F.
  - LB @0x203 -> 0xFFFFFF80.
  - LBU @0x203 -> 0x00000080.
  - LH @0x202 -> 0xFFFF80FF.
  - LHU @0x202 -> 0x000080FF.
- Misaligned and illegal requests:
  - LW @0x102, SH @0x101 and funct3 = 011 -> each gives rsp_valid in cycle 1 with rsp_err = 1.
  - No mem_rw = 1 cycle occurs; memory contents are unchanged.
- Reset mid-RMW: SH accepted, rst_n low during RD_CAP -> no write, state IDLE, rsp_valid never asserted, target word unchanged.
